// File: rtl/ex_mc_stage.sv
// Execute stage: source operand muxing, ALU / multiplier / iterative divider,
// and the registered EX/MEM payload behind a valid/ready handshake.
//
// Divider FSM
//   state  | meaning
//   IDLE   | no division in flight, operands are latched on a divide start
//   BUSY   | restoring division, DIV_BITS_PER_CYCLE quotient bits per cycle
//   DONE   | result valid on div_res, held until the instruction is accepted
module ex_mc_stage #(
   parameter logic [31:0] RESET_PC           = 32'h1c000000,
   parameter int          DIV_BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        out_valid,
   input  logic        out_ready,
   input  logic        flush,
   input  logic [31:0] pc,
   input  logic [31:0] imm,
   input  logic [31:0] rj_value,
   input  logic [31:0] rkd_value,
   input  logic [11:0] alu_op,
   input  logic [2:0]  mul_op,
   input  logic [3:0]  div_op,
   input  logic        src1_is_pc,
   input  logic        src2_is_imm,
   input  logic [7:0]  load_op,
   input  logic        res_from_mem,
   input  logic        gr_we,
   input  logic        mem_we,
   input  logic [4:0]  dest,
   output logic [31:0] result,
   output logic        fwd_valid,
   output logic        div_busy,
   output logic [31:0] result_out,
   output logic [31:0] pc_out,
   output logic [7:0]  load_op_out,
   output logic        res_from_mem_out,
   output logic        gr_we_out,
   output logic        mem_we_out,
   output logic [4:0]  dest_out,
   output logic [31:0] rkd_value_out
);

   localparam int         N        = 32 / DIV_BITS_PER_CYCLE;
   localparam logic [4:0] CNT_LAST = 5'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_e;

   div_state_e  state, state_nx;
   logic [4:0]  div_cnt;
   logic [31:0] div_a, div_b, div_q, div_r;
   logic        div_qsign, div_rsign;
   logic [31:0] a_nx, q_nx;
   logic [32:0] r_nx;

   logic [31:0] src1, src2;
   logic [31:0] add_res, sub_res, sra_res;
   logic [31:0] alu_res, mul_res, div_res;
   logic [32:0] mul_a, mul_b;
   logic [63:0] mul_prod;
   logic        div_signed, x_neg, y_neg, div_start, ready_go, capture;
   logic [31:0] abs_x, abs_y, quo_fix, rem_fix;

   assign src1 = src1_is_pc  ? pc  : rj_value;
   assign src2 = src2_is_imm ? imm : rkd_value;

   // alu_op one-hot: add sub slt sltu and nor or xor sll srl sra lui
   assign add_res = src1 + src2;
   assign sub_res = src1 - src2;
   assign sra_res = $signed(src1) >>> src2[4:0];
   assign alu_res = ({32{alu_op[0]}}  & add_res)
                  | ({32{alu_op[1]}}  & sub_res)
                  | ({32{alu_op[2]}}  & {31'b0, $signed(src1) < $signed(src2)})
                  | ({32{alu_op[3]}}  & {31'b0, src1 < src2})
                  | ({32{alu_op[4]}}  & (src1 & src2))
                  | ({32{alu_op[5]}}  & ~(src1 | src2))
                  | ({32{alu_op[6]}}  & (src1 | src2))
                  | ({32{alu_op[7]}}  & (src1 ^ src2))
                  | ({32{alu_op[8]}}  & (src1 << src2[4:0]))
                  | ({32{alu_op[9]}}  & (src1 >> src2[4:0]))
                  | ({32{alu_op[10]}} & sra_res)
                  | ({32{alu_op[11]}} & src2);

   // mul_op one-hot: mul.w, mulh.w, mulh.wu; one 33x33 signed multiply covers all three
   assign mul_a    = {mul_op[1] & src1[31], src1};
   assign mul_b    = {mul_op[1] & src2[31], src2};
   assign mul_prod = {{31{mul_a[32]}}, mul_a} * {{31{mul_b[32]}}, mul_b};
   assign mul_res  = ({32{mul_op[0]}} & mul_prod[31:0])
                   | ({32{mul_op[1] | mul_op[2]}} & mul_prod[63:32]);

   // Signs are only latched for signed ops, so unsigned results skip the fix-up
   assign div_signed = div_op[0] | div_op[1];
   assign x_neg      = div_signed & src1[31];
   assign y_neg      = div_signed & src2[31];
   assign abs_x      = x_neg ? (32'd0 - src1) : src1;
   assign abs_y      = y_neg ? (32'd0 - src2) : src2;
   assign div_start  = in_valid & (|div_op) & ~flush;

   assign quo_fix = div_qsign ? (32'd0 - div_q) : div_q;
   assign rem_fix = div_rsign ? (32'd0 - div_r) : div_r;
   assign div_res = (state == S_DONE)
                  ? (({32{div_op[0] | div_op[2]}} & quo_fix) | ({32{div_op[1] | div_op[3]}} & rem_fix))
                  : 32'd0;

   assign result    = alu_res | mul_res | div_res;
   assign ready_go  = ~(|div_op) | (state == S_DONE);
   assign fwd_valid = in_valid & ready_go;
   assign in_ready  = resetn & ~flush & (~in_valid | (ready_go & out_ready));
   assign div_busy  = (state == S_BUSY);
   assign capture   = in_valid & ready_go & out_ready & ~flush;

   // Restoring division steps for one cycle; a zero divisor naturally yields all-ones / dividend
   always_comb begin
      a_nx = div_a;
      q_nx = div_q;
      r_nx = {1'b0, div_r};
      for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
         r_nx = {r_nx[31:0], a_nx[31]};
         a_nx = {a_nx[30:0], 1'b0};
         if (r_nx >= {1'b0, div_b}) begin
            r_nx = r_nx - {1'b0, div_b};
            q_nx = {q_nx[30:0], 1'b1};
         end else begin
            q_nx = {q_nx[30:0], 1'b0};
         end
      end
   end

   // Divider next-state; flush overrides every transition
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (div_start) state_nx = S_BUSY;
         S_BUSY:  if (div_cnt == CNT_LAST) state_nx = S_DONE;
         S_DONE:  if (in_valid & out_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (flush) state_nx = S_IDLE;
   end

   // Divider state, step counter and datapath registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= S_IDLE;
         div_cnt   <= 5'd0;
         div_a     <= 32'd0;
         div_b     <= 32'd0;
         div_q     <= 32'd0;
         div_r     <= 32'd0;
         div_qsign <= 1'b0;
         div_rsign <= 1'b0;
      end else begin
         state <= state_nx;
         if (flush) begin
            div_cnt <= 5'd0;
         end else if (state == S_IDLE && div_start) begin
            div_cnt   <= 5'd0;
            div_a     <= abs_x;
            div_b     <= abs_y;
            div_q     <= 32'd0;
            div_r     <= 32'd0;
            div_qsign <= x_neg ^ y_neg;
            div_rsign <= x_neg;
         end else if (state == S_BUSY) begin
            div_cnt <= (div_cnt == CNT_LAST) ? 5'd0 : div_cnt + 5'd1;
            div_a   <= a_nx;
            div_q   <= q_nx;
            div_r   <= r_nx[31:0];
         end
      end
   end

   // EX/MEM handshake and payload registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         out_valid        <= 1'b0;
         result_out       <= 32'd0;
         pc_out           <= RESET_PC;
         load_op_out      <= 8'd0;
         res_from_mem_out <= 1'b0;
         gr_we_out        <= 1'b0;
         mem_we_out       <= 1'b0;
         dest_out         <= 5'd0;
         rkd_value_out    <= 32'd0;
      end else begin
         if (flush) out_valid <= 1'b0;
         else if (out_ready) out_valid <= in_valid & ready_go;
         if (capture) begin
            result_out       <= result;
            pc_out           <= pc;
            load_op_out      <= load_op;
            res_from_mem_out <= res_from_mem;
            gr_we_out        <= gr_we;
            mem_we_out       <= mem_we;
            dest_out         <= dest;
            rkd_value_out    <= rkd_value;
         end
      end
   end

endmodule

// File: tb/tb_ex_mc_stage.sv
// Bench for ex_mc_stage: vector table through a scoreboard plus hand-written
// sequences for flush, reset, back-pressure and the 4-bit-per-cycle divider.
module tb_ex_mc_stage;

   logic        clk = 1'b0, resetn = 1'b0, in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
   logic [31:0] pc = '0, imm = '0, rj_value = '0, rkd_value = '0;
   logic [11:0] alu_op = '0;
   logic [2:0]  mul_op = '0;
   logic [3:0]  div_op = '0;
   logic        src1_is_pc = 1'b0, src2_is_imm = 1'b0;
   logic [7:0]  load_op = '0;
   logic        res_from_mem = 1'b0, gr_we = 1'b0, mem_we = 1'b0;
   logic [4:0]  dest = '0;

   logic        in_ready, out_valid, fwd_valid, div_busy, res_from_mem_out, gr_we_out, mem_we_out;
   logic [31:0] result, result_out, pc_out, rkd_value_out;
   logic [7:0]  load_op_out;
   logic [4:0]  dest_out;

   logic        in_ready_4, out_valid_4, fwd_valid_4, div_busy_4, res_from_mem_out_4, gr_we_out_4, mem_we_out_4;
   logic [31:0] result_4, result_out_4, pc_out_4, rkd_value_out_4;
   logic [7:0]  load_op_out_4;
   logic [4:0]  dest_out_4;

   ex_mc_stage u_dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
      .pc(pc), .imm(imm), .rj_value(rj_value), .rkd_value(rkd_value),
      .alu_op(alu_op), .mul_op(mul_op), .div_op(div_op),
      .src1_is_pc(src1_is_pc), .src2_is_imm(src2_is_imm),
      .load_op(load_op), .res_from_mem(res_from_mem), .gr_we(gr_we), .mem_we(mem_we), .dest(dest),
      .result(result), .fwd_valid(fwd_valid), .div_busy(div_busy),
      .result_out(result_out), .pc_out(pc_out), .load_op_out(load_op_out),
      .res_from_mem_out(res_from_mem_out), .gr_we_out(gr_we_out), .mem_we_out(mem_we_out),
      .dest_out(dest_out), .rkd_value_out(rkd_value_out)
   );

   ex_mc_stage #(.DIV_BITS_PER_CYCLE(4)) u_dut4 (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready_4),
      .out_valid(out_valid_4), .out_ready(out_ready), .flush(flush),
      .pc(pc), .imm(imm), .rj_value(rj_value), .rkd_value(rkd_value),
      .alu_op(alu_op), .mul_op(mul_op), .div_op(div_op),
      .src1_is_pc(src1_is_pc), .src2_is_imm(src2_is_imm),
      .load_op(load_op), .res_from_mem(res_from_mem), .gr_we(gr_we), .mem_we(mem_we), .dest(dest),
      .result(result_4), .fwd_valid(fwd_valid_4), .div_busy(div_busy_4),
      .result_out(result_out_4), .pc_out(pc_out_4), .load_op_out(load_op_out_4),
      .res_from_mem_out(res_from_mem_out_4), .gr_we_out(gr_we_out_4), .mem_we_out(mem_we_out_4),
      .dest_out(dest_out_4), .rkd_value_out(rkd_value_out_4)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum {OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRA,
                 OP_MUL, OP_MULH, OP_MULHU, OP_DIVW, OP_MODW, OP_DIVWU, OP_MODWU} op_e;

   typedef struct {
      op_e         op;
      logic [31:0] a, b;
      logic        s1pc, s2imm;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [31:0] res, pc, rkd;
      logic [4:0]  dest;
      int          t0;
      int          lat;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];
   sb_t  mon_e;
   int   checks = 0, errors = 0, seq_n = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic add_vec(input op_e op, input logic [31:0] a, b, input logic s1pc, s2imm,
                          input logic [31:0] exp);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.s1pc = s1pc; v.s2imm = s2imm; v.exp = exp;
      vecs.push_back(v);
   endtask

   function automatic bit is_div(input op_e op);
      return op inside {OP_DIVW, OP_MODW, OP_DIVWU, OP_MODWU};
   endfunction

   function automatic logic [31:0] ref_div(input op_e op, input logic [31:0] a, b);
      logic sgn, want_q;
      sgn    = (op == OP_DIVW) || (op == OP_MODW);
      want_q = (op == OP_DIVW) || (op == OP_DIVWU);
      if (b == 32'd0) return want_q ? ((sgn && a[31]) ? 32'd1 : 32'hFFFFFFFF) : a;
      if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) return want_q ? 32'h80000000 : 32'd0;
      if (sgn) return want_q ? 32'($signed(a) / $signed(b)) : 32'($signed(a) % $signed(b));
      return want_q ? a / b : a % b;
   endfunction

   task automatic set_op(input op_e op);
      alu_op = '0; mul_op = '0; div_op = '0;
      case (op)
         OP_ADD:   alu_op[0]  = 1'b1;
         OP_SUB:   alu_op[1]  = 1'b1;
         OP_SLT:   alu_op[2]  = 1'b1;
         OP_SLTU:  alu_op[3]  = 1'b1;
         OP_AND:   alu_op[4]  = 1'b1;
         OP_OR:    alu_op[6]  = 1'b1;
         OP_XOR:   alu_op[7]  = 1'b1;
         OP_SLL:   alu_op[8]  = 1'b1;
         OP_SRA:   alu_op[10] = 1'b1;
         OP_MUL:   mul_op[0]  = 1'b1;
         OP_MULH:  mul_op[1]  = 1'b1;
         OP_MULHU: mul_op[2]  = 1'b1;
         OP_DIVW:  div_op[0]  = 1'b1;
         OP_MODW:  div_op[1]  = 1'b1;
         OP_DIVWU: div_op[2]  = 1'b1;
         OP_MODWU: div_op[3]  = 1'b1;
         default: ;
      endcase
   endtask

   task automatic idle();
      in_valid = 1'b0;
      set_op(OP_ADD);
      alu_op = '0;
      @(posedge clk); #1;
   endtask

   // Present one instruction, queue its expected payload, wait (bounded) for acceptance.
   task automatic issue(input op_e op, input logic [31:0] a, b, input logic s1pc, s2imm,
                        input logic [31:0] exp);
      sb_t e;
      int  waits;
      seq_n++;
      set_op(op);
      src1_is_pc  = s1pc;
      src2_is_imm = s2imm;
      pc          = s1pc ? a : 32'h1c001000 + 32'(seq_n * 4);
      rj_value    = s1pc ? ~a : a;
      imm         = s2imm ? b : ~b;
      rkd_value   = s2imm ? ~b : b;
      dest        = 5'(seq_n);
      gr_we       = 1'b1;
      in_valid    = 1'b1;
      out_ready   = 1'b1;
      e.res = exp; e.pc = pc; e.rkd = rkd_value; e.dest = dest; e.t0 = cyc;
      e.lat = is_div(op) ? 34 : 1;
      sb.push_back(e);
      waits = 0;
      @(negedge clk);
      while (!in_ready && waits <= 100) begin
         waits++;
         @(negedge clk);
      end
      chk("in_ready_low_cycles", 32'(waits), is_div(op) ? 32'd33 : 32'd0);
      chk("fwd_valid_at_accept", {31'b0, fwd_valid}, 32'd1);
      @(posedge clk); #1;
   endtask

   // Scoreboard consumer: one entry per MEM-side transfer
   always @(negedge clk) begin
      if (resetn && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: result_out %h pc_out %h with nothing outstanding", result_out, pc_out);
         end else begin
            mon_e = sb.pop_front();
            chk("result_out", result_out, mon_e.res);
            chk("pc_out", pc_out, mon_e.pc);
            chk("dest_out", {27'b0, dest_out}, {27'b0, mon_e.dest});
            chk("rkd_value_out", rkd_value_out, mon_e.rkd);
            if (mon_e.lat >= 0) chk("latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          waits, cnt, lat4;
      logic [31:0] r4, p4, ra, rb;
      op_e         rop;

      add_vec(OP_ADD,   32'd5,        32'd7,        1'b0, 1'b0, 32'd12);
      add_vec(OP_ADD,   32'hFFFFFFFF, 32'd1,        1'b0, 1'b1, 32'd0);
      add_vec(OP_SUB,   32'd3,        32'd5,        1'b0, 1'b0, 32'hFFFFFFFE);
      add_vec(OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 32'hF000F000);
      add_vec(OP_OR,    32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 32'hFFF0FFF0);
      add_vec(OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 32'h0FF00FF0);
      add_vec(OP_SLTU,  32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 32'd1);
      add_vec(OP_SLT,   32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 32'd1);
      add_vec(OP_SLL,   32'd1,        32'd31,       1'b0, 1'b1, 32'h80000000);
      add_vec(OP_SRA,   32'h80000000, 32'd4,        1'b0, 1'b0, 32'hF8000000);
      add_vec(OP_ADD,   32'h1c000000, 32'd4,        1'b1, 1'b1, 32'h1c000004);
      add_vec(OP_MUL,   32'd7,        32'd6,        1'b0, 1'b0, 32'd42);
      add_vec(OP_MULH,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0);
      add_vec(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE);
      add_vec(OP_DIVW,  32'hFFFFFFF9, 32'd2,        1'b0, 1'b0, 32'hFFFFFFFD);
      add_vec(OP_MODW,  32'hFFFFFFF9, 32'd2,        1'b0, 1'b0, 32'hFFFFFFFF);
      add_vec(OP_DIVWU, 32'd100,      32'd0,        1'b0, 1'b0, 32'hFFFFFFFF);
      add_vec(OP_MODWU, 32'd100,      32'd0,        1'b0, 1'b0, 32'd100);
      add_vec(OP_DIVW,  32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h80000000);
      add_vec(OP_MODW,  32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0);
      add_vec(OP_DIVWU, 32'hFFFFFFFF, 32'h10,       1'b0, 1'b0, 32'h0FFFFFFF);
      add_vec(OP_MODW,  32'd7,        32'hFFFFFFFE, 1'b0, 1'b0, 32'd1);
      add_vec(OP_DIVW,  32'hFFFFFFF9, 32'd0,        1'b0, 1'b0, 32'd1);
      add_vec(OP_MODW,  32'hFFFFFFF9, 32'd0,        1'b0, 1'b0, 32'hFFFFFFF9);

      // Reset state
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset_pc_out", pc_out, 32'h1c000000);
      chk("reset_result_out", result_out, 32'd0);
      chk("reset_div_busy", {31'b0, div_busy}, 32'd0);
      chk("reset_in_ready", {31'b0, in_ready}, 32'd0);
      resetn = 1'b1;
      @(posedge clk); #1;

      // Vector table, back to back
      for (int i = 0; i < vecs.size(); i++)
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].s1pc, vecs[i].s2imm, vecs[i].exp);

      // Random divisions against the reference model
      for (int k = 0; k < 4; k++) begin
         case (k)
            0: rop = OP_DIVW;
            1: rop = OP_MODW;
            2: rop = OP_DIVWU;
            default: rop = OP_MODWU;
         endcase
         ra = $urandom;
         rb = 32'($urandom_range(1, 50000));
         if (k % 2 == 0) rb = 32'd0 - rb;
         issue(rop, ra, rb, 1'b0, 1'b0, ref_div(rop, ra, rb));
      end
      idle(); idle();

      // Divide completes while MEM stalls; result held in DONE
      set_op(OP_DIVW);
      src1_is_pc = 1'b0; src2_is_imm = 1'b0;
      rj_value = 32'hFFFFFFF9; rkd_value = 32'd2; pc = 32'h1c002000; dest = 5'd9;
      out_ready = 1'b0; in_valid = 1'b1;
      mon_e.res = 32'hFFFFFFFD; mon_e.pc = pc; mon_e.rkd = 32'd2; mon_e.dest = 5'd9;
      mon_e.t0 = cyc; mon_e.lat = -1;
      sb.push_back(mon_e);
      waits = 0;
      @(negedge clk);
      while (!fwd_valid && waits <= 100) begin
         waits++;
         @(negedge clk);
      end
      chk("hold_done_cycle", 32'(waits), 32'd33);
      for (int k = 0; k < 5; k++) begin
         chk("hold_out_valid", {31'b0, out_valid}, 32'd0);
         chk("hold_div_busy", {31'b0, div_busy}, 32'd0);
         chk("hold_result", result, 32'hFFFFFFFD);
         chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("hold_release_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      idle(); idle();

      // Flush during BUSY
      set_op(OP_DIVW);
      rj_value = 32'd1000; rkd_value = 32'd7; pc = 32'h1c002100;
      in_valid = 1'b1; out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("flush_pre_busy", {31'b0, div_busy}, 32'd1);
      flush = 1'b1;
      #1;
      chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0; div_op = '0;
      chk("flush_div_busy", {31'b0, div_busy}, 32'd0);
      chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
      issue(OP_ADD, 32'd1, 32'd2, 1'b0, 1'b0, 32'd3);
      idle();

      // Flush together with acceptance: nothing captured
      set_op(OP_ADD);
      rj_value = 32'd10; rkd_value = 32'd20; pc = 32'h1c002200;
      in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_accept_out_valid", {31'b0, out_valid}, 32'd0);
      idle();

      // Reset in the middle of a division
      set_op(OP_DIVWU);
      rj_value = 32'd1000; rkd_value = 32'd3; pc = 32'h1c002300;
      in_valid = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_pre_busy", {31'b0, div_busy}, 32'd1);
      resetn = 1'b0;
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      chk("rst_div_busy", {31'b0, div_busy}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      resetn = 1'b1;
      in_valid = 1'b0;
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk("rst_no_stale_out", 32'(cnt), 32'd0);
      @(posedge clk); #1;
      issue(OP_SUB, 32'd10, 32'd3, 1'b0, 1'b0, 32'd7);
      idle();

      // Four quotient bits per cycle: 10 cycles to out_valid on the second instance
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      set_op(OP_DIVWU);
      rj_value = 32'd100; rkd_value = 32'd7; pc = 32'h1c003000; dest = 5'd3;
      in_valid = 1'b1; out_ready = 1'b1;
      mon_e.res = 32'd14; mon_e.pc = pc; mon_e.rkd = 32'd7; mon_e.dest = 5'd3;
      mon_e.t0 = cyc; mon_e.lat = 34;
      sb.push_back(mon_e);
      lat4 = -1; r4 = '0; p4 = '0; waits = 0;
      @(negedge clk);
      while (!in_ready && waits <= 100) begin
         if (out_valid_4 && lat4 < 0) begin
            lat4 = cyc - mon_e.t0;
            r4   = result_out_4;
            p4   = pc_out_4;
         end
         waits++;
         @(negedge clk);
      end
      chk("r4_latency", 32'(lat4), 32'd10);
      chk("r4_result_out", r4, 32'd14);
      chk("r4_pc_out", p4, 32'h1c003000);
      @(posedge clk); #1;
      idle();

      waits = 0;
      while (sb.size() != 0 && waits < 60) begin
         @(posedge clk); #1;
         waits++;
      end
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_mc_stage.md
# ex_mc_stage

Execute pipeline stage with a multi-cycle iterative divider, replacing the single-cycle EX stage between ID and MEM. It computes the source operands, combines the ALU, multiplier and divider results, and registers the EX/MEM payload behind a valid/ready handshake. Unlike the single-cycle stage, it back-pressures ID while a division is in flight, supports a pipeline flush, and has a configurable divider throughput.

## Interface
Parameters:
- `RESET_PC`, default `32'h1c000000`: reset value of `pc_out`.
- `DIV_BITS_PER_CYCLE`, default `1`: quotient bits resolved per cycle. Legal values are 1, 2 and 4. N = 32 / `DIV_BITS_PER_CYCLE`.

Ports:
- `clk`, in, 1: the single clock.
- `resetn`, in, 1: synchronous, active-low reset.
- `in_valid`, in, 1 / `in_ready`, out, 1: handshake with the ID stage.
- `out_valid`, out, 1 / `out_ready`, in, 1: handshake with the MEM stage.
- `flush`, in, 1: kills the current instruction and any division in progress.
- `pc`, in, 32; `imm`, in, 32; `rj_value`, in, 32; `rkd_value`, in, 32: operand sources.
- `alu_op`, in, 12; `mul_op`, in, 3: one-hot operation selects for the existing alu and multiplier.
- `div_op`, in, 4: one-hot select, bit0 div.w, bit1 mod.w, bit2 div.wu, bit3 mod.wu.
- `src1_is_pc`, in, 1; `src2_is_imm`, in, 1: operand muxes.
- `load_op`, in, 8; `res_from_mem`, in, 1; `gr_we`, in, 1; `mem_we`, in, 1; `dest`, in, 5: payload passed through to MEM.
- `result`, out, 32: combinational forwarding value.
- `fwd_valid`, out, 1: `in_valid & ready_go`.
- `div_busy`, out, 1: high in BUSY.
- Registered outputs to MEM: `result_out` 32, `pc_out` 32, `load_op_out` 8, `res_from_mem_out` 1, `gr_we_out` 1, `mem_we_out` 1, `dest_out` 5, `rkd_value_out` 32.

## Operation
Operands and result combining:
- src1 = `src1_is_pc` ? `pc` : `rj_value`. src2 = `src2_is_imm` ? `imm` : `rkd_value`.
- `result` = alu_res | mul_res | div_res. Each unit drives 0 when it is not selected.
- div_res is 0 unless the divider is in DONE.

Divider FSM:
- States are IDLE, BUSY and DONE. A counter counts 0..N-1.
- IDLE→BUSY when `in_valid & |div_op & ~flush`. On that edge, latch |src1|, |src2|, the signedness, the quotient sign (x31^y31) and the remainder sign (x31). Operands are taken as absolute values only for signed ops.
- BUSY runs a restoring division at `DIV_BITS_PER_CYCLE` bits per cycle. BUSY→DONE after N cycles.
- DONE holds the result. DONE→IDLE on the edge where the instruction is accepted (`in_valid & out_ready`).
- `flush` forces IDLE from any state on the next edge.
- Signed results apply the latched signs (two's-complement negate).
- Divide by zero: quotient = `0xFFFFFFFF` for unsigned. For signed, the sign fix-up is applied to the raw quotient `0xFFFFFFFF`. Remainder = dividend.
- Signed overflow `0x80000000 / 0xFFFFFFFF`: quotient = `0x80000000`, remainder = 0.

Handshake:
- `ready_go` = `~|div_op | (state==DONE)`.
- `in_ready` = `resetn & ~flush & (~in_valid | ready_go & out_ready)`.
- On `resetn` low: `out_valid` clears, else if `flush`: `out_valid` clears, else if `out_ready`: `out_valid` <= `in_valid & ready_go`.
- Payload registers load when `in_valid & ready_go & out_ready & ~flush`, and otherwise hold.

Reset values: `out_valid` 0, `pc_out` `RESET_PC`, all other registered outputs 0, FSM in IDLE with counter 0.

## Timing
- Non-divide instruction: zero extra latency. Presented in cycle t with `out_ready` high, it is captured at the end of t and `out_valid` is high in t+1.
- Divide presented in cycle t:
  - BUSY covers cycles t+1 .. t+N.
  - DONE is reached in t+N+1, when `ready_go` goes high.
  - The instruction is captured at the end of t+N+1 and `out_valid` is high in t+N+2.
  - With the default parameter that is 34 cycles from presentation to `out_valid`.
- `out_ready` low in DONE: the result is held and no new division starts until acceptance.
- Back-to-back divides: the FSM returns to IDLE on the acceptance edge, and the next divide starts on the following edge.
- `flush` together with acceptance: `flush` wins. Nothing is captured and `out_valid` is 0 next cycle.
- `resetn` low mid-division: the FSM goes to IDLE and the counter to 0 next edge. No stale result appears after reset.
- `in_ready` is 0 during reset and during flush cycles.

## Test plan
- Reset with `resetn`=0 for 2 cycles → `out_valid`=0, `pc_out`=`0x1c000000`, `result_out`=0, `div_busy`=0.
- add.w with rj=5, rk=7, `out_ready`=1 → `out_valid` next cycle, `result_out`=12, `in_ready` never deasserts.
- div.w with rj=`0xFFFFFFF9` (-7), rk=2, default parameter → quotient `0xFFFFFFFD` (-3). `in_ready` low for 33 cycles, `out_valid` 34 cycles after presentation. The same operands on mod.w → `0xFFFFFFFF` (-1).
- div.wu 100/0 → `0xFFFFFFFF`. mod.wu 100/0 → 100. div.w `0x80000000`/`0xFFFFFFFF` → `0x80000000`. mod.w with the same operands → 0.
- Divide in BUSY with `flush` pulsed at cycle 10 → `div_busy`=0 next cycle, no `out_valid`. A following add.w completes normally in 1 cycle.
- div.w completes while `out_ready`=0 for 5 cycles → the result is held in DONE and `out_valid` is unchanged. Captured on the first `out_ready`=1 cycle, with `pc_out` matching the divide's PC. With `DIV_BITS_PER_CYCLE`=4, latency is 10 cycles.
